// File: rtl/multicycle_cpu_if.sv
// rtl/multicycle_cpu_if.sv - instruction fetch handshake between the core and instruction memory
interface multicycle_cpu_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32
);
  logic                   req_valid;
  logic [ADDR_WIDTH-1:0]  pc;
  logic                   instr_valid;
  logic [INSTR_WIDTH-1:0] instr;

  modport master (output req_valid, output pc, input instr_valid, input instr);
  modport slave  (input req_valid, input pc, output instr_valid, output instr);
endinterface

// File: rtl/multicycle_cpu.sv
// rtl/multicycle_cpu.sv - multi-cycle 32-bit CPU core
module multicycle_cpu #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int DMEM_SIZE   = 4096
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  multicycle_cpu_if.master                imem,
  output logic                            debug_instr_is_completed_o,
  output logic [31:0][DATA_WIDTH-1:0]     debug_regs_o,
  output logic [ADDR_WIDTH-1:0]           debug_pc_o,
  output logic [INSTR_WIDTH-1:0]          debug_instr_o
);
  localparam int DMEM_AW = $clog2(DMEM_SIZE);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_COMMIT} state_t;
  typedef enum logic [3:0] {
    OP_ADD, OP_LW, OP_SW, OP_SUB, OP_AND, OP_MUL, OP_DIV, OP_OR,
    OP_XOR, OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_JMP, OP_NOP_E, OP_NOP_F
  } opcode_t;

  state_t                      state_q, state_d;
  logic [ADDR_WIDTH-1:0]       pc_q, next_pc_q, br_off_q, next_pc_d;
  logic [INSTR_WIDTH-1:0]      instr_q, debug_instr_q;
  logic [ADDR_WIDTH-1:0]       debug_pc_q;
  logic [DATA_WIDTH-1:0]       a_q, b_q, d_q, alu_res;
  logic [DMEM_AW-1:0]          maddr_q;
  logic [31:0][DATA_WIDTH-1:0] regs_q;
  logic [DATA_WIDTH-1:0]       dmem_q [DMEM_SIZE];
  logic                        is_alu, taken;

  opcode_t               op;
  logic [4:0]            rd, rb, ra;
  logic [17:0]           mem_off, br_off;
  logic [DATA_WIDTH-1:0] maddr_sum;

  assign op        = opcode_t'(instr_q[3:0]);
  assign rd        = instr_q[8:4];
  assign rb        = instr_q[13:9];
  assign ra        = instr_q[18:14];
  assign mem_off   = instr_q[31:14];
  assign br_off    = {instr_q[31:19], instr_q[8:4]};
  assign maddr_sum = {{(DATA_WIDTH-18){mem_off[17]}}, mem_off} + regs_q[rb];

  always_comb begin
    alu_res = '0;
    is_alu  = 1'b0;
    taken   = 1'b0;
    case (op)
      OP_ADD: begin alu_res = a_q + b_q; is_alu = 1'b1; end
      OP_SUB: begin alu_res = a_q - b_q; is_alu = 1'b1; end
      OP_AND: begin alu_res = a_q & b_q; is_alu = 1'b1; end
      OP_MUL: begin alu_res = a_q * b_q; is_alu = 1'b1; end
      OP_DIV: begin alu_res = (b_q == '0) ? '1 : a_q / b_q; is_alu = 1'b1; end
      OP_OR:  begin alu_res = a_q | b_q; is_alu = 1'b1; end
      OP_XOR: begin alu_res = a_q ^ b_q; is_alu = 1'b1; end
      OP_BEQ: taken = (a_q == b_q);
      OP_BNE: taken = (a_q != b_q);
      OP_BLT: taken = (a_q < b_q);
      OP_BGE: taken = (a_q >= b_q);
      default: ;
    endcase
    if (op == OP_JMP) next_pc_d = ADDR_WIDTH'(a_q);
    else if (taken)   next_pc_d = pc_q + br_off_q;
    else              next_pc_d = pc_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (imem.instr_valid) state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   state_d = (op == OP_LW || op == OP_SW) ? S_MEM : S_COMMIT;
      S_MEM:    state_d = S_COMMIT;
      S_COMMIT: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= S_FETCH;
      pc_q          <= ADDR_WIDTH'(1);
      next_pc_q     <= '0;
      br_off_q      <= '0;
      instr_q       <= '0;
      a_q           <= '0;
      b_q           <= '0;
      d_q           <= '0;
      maddr_q       <= '0;
      debug_pc_q    <= '0;
      debug_instr_q <= '0;
      for (int i = 0; i < 32; i++) regs_q[i] <= DATA_WIDTH'(i);
      for (int i = 0; i < DMEM_SIZE; i++) dmem_q[i] <= DATA_WIDTH'(i);
    end else begin
      state_q <= state_d;
      case (state_q)
        S_FETCH: if (imem.instr_valid) instr_q <= imem.instr;
        S_DECODE: begin
          a_q      <= regs_q[ra];
          b_q      <= regs_q[rb];
          d_q      <= regs_q[rd];
          maddr_q  <= maddr_sum[DMEM_AW-1:0];
          br_off_q <= {{(ADDR_WIDTH-18){br_off[17]}}, br_off};
        end
        S_EXEC: begin
          next_pc_q <= next_pc_d;
          if (is_alu) regs_q[rd] <= alu_res;
        end
        S_MEM: begin
          if (op == OP_LW) regs_q[rd] <= dmem_q[maddr_q];
          else             dmem_q[maddr_q] <= d_q;
        end
        S_COMMIT: pc_q <= next_pc_q;
        default: ;
      endcase
      // Capture the debug view as the instruction enters COMMIT so it holds for the pulse.
      if (state_d == S_COMMIT && state_q != S_COMMIT) begin
        debug_pc_q    <= pc_q;
        debug_instr_q <= instr_q;
      end
    end
  end

  assign imem.req_valid             = (state_q == S_FETCH) && !rst_i;
  assign imem.pc                    = pc_q;
  assign debug_instr_is_completed_o = (state_q == S_COMMIT);
  assign debug_regs_o               = regs_q;
  assign debug_pc_o                 = debug_pc_q;
  assign debug_instr_o              = debug_instr_q;
endmodule

// File: tb/tb_multicycle_cpu.sv
// tb/tb_multicycle_cpu.sv - directed self-checking bench for multicycle_cpu
module tb_multicycle_cpu;
  logic              clk = 1'b0;
  logic              rst;
  logic              dbg_done;
  logic [31:0][31:0] dbg_regs;
  logic [31:0]       dbg_pc;
  logic [31:0]       dbg_instr;
  int                checks = 0;
  int                errors = 0;
  int                commits = 0;

  multicycle_cpu_if #(.ADDR_WIDTH(32), .INSTR_WIDTH(32)) imem ();

  multicycle_cpu dut (
    .clk_i                      (clk),
    .rst_i                      (rst),
    .imem                       (imem),
    .debug_instr_is_completed_o (dbg_done),
    .debug_regs_o               (dbg_regs),
    .debug_pc_o                 (dbg_pc),
    .debug_instr_o              (dbg_instr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (dbg_done) commits++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [3:0] op, input logic [4:0] rd,
                                        input logic [4:0] rb, input logic [4:0] ra);
    return {13'd0, ra, rb, rd, op};
  endfunction

  function automatic logic [31:0] enc_m(input logic [3:0] op, input logic [4:0] rd,
                                        input logic [4:0] rb, input logic [17:0] off);
    return {off, rb, rd, op};
  endfunction

  task automatic wait_req(input logic [31:0] exp_pc);
    int n = 0;
    while (!imem.req_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("fetch_req", 32'(imem.req_valid), 32'd1);
    check("fetch_pc", imem.pc, exp_pc);
  endtask

  task automatic run_instr(input logic [31:0] exp_pc, input logic [31:0] instr, input int lat);
    int n = 0;
    wait_req(exp_pc);
    for (int i = 1; i < lat; i++) begin
      @(negedge clk);
      check("hold_req", 32'(imem.req_valid), 32'd1);
      check("hold_pc", imem.pc, exp_pc);
    end
    imem.instr       = instr;
    imem.instr_valid = 1'b1;
    @(negedge clk);
    imem.instr_valid = 1'b0;
    imem.instr       = '0;
    while (!dbg_done && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("commit", 32'(dbg_done), 32'd1);
    check("commit_pc", dbg_pc, exp_pc);
    check("commit_instr", dbg_instr, instr);
    @(negedge clk);
    check("commit_pulse", 32'(dbg_done), 32'd0);
  endtask

  initial begin
    rst              = 1'b1;
    imem.instr_valid = 1'b0;
    imem.instr       = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_req", 32'(imem.req_valid), 32'd0);
    check("rst_done", 32'(dbg_done), 32'd0);
    check("rst_dbg_pc", dbg_pc, 32'd0);
    check("rst_dbg_instr", dbg_instr, 32'd0);
    check("rst_pc", imem.pc, 32'd1);
    check("rst_r5", dbg_regs[5], 32'd5);
    rst = 1'b0;

    run_instr(1, 32'h0000_4470, 1);
    check("add_r7", dbg_regs[7], 32'd3);
    run_instr(2, 32'h0004_46F1, 3);
    check("lw_r15", dbg_regs[15], 32'd20);
    run_instr(3, enc_m(4'h1, 5'd24, 5'd12, 18'h3FFEF), 2);
    check("lw_wrap_r24", dbg_regs[24], 32'd4091);
    run_instr(4, 32'h0003_6212, 1);
    check("sw_r1", dbg_regs[1], 32'd1);
    check("sw_r17", dbg_regs[17], 32'd17);
    run_instr(5, enc_m(4'h1, 5'd9, 5'd0, 18'd30), 3);
    check("lw_after_sw", dbg_regs[9], 32'd1);
    run_instr(6, enc_r(4'h3, 5'd10, 5'd3, 5'd20), 1);
    check("sub_r10", dbg_regs[10], 32'd17);
    run_instr(7, 32'h000A_0DF9, 2);
    run_instr(8, 32'h0009_8DF9, 1);
    run_instr(71, 32'hFFF9_8D69, 3);
    run_instr(61, enc_r(4'h5, 5'd11, 5'd14, 5'd13), 1);
    check("mul_r11", dbg_regs[11], 32'd182);
    run_instr(62, enc_r(4'h6, 5'd12, 5'd0, 5'd20), 2);
    check("div0_r12", dbg_regs[12], 32'hFFFF_FFFF);
    run_instr(63, enc_r(4'h6, 5'd16, 5'd7, 5'd29), 1);
    check("div_r16", dbg_regs[16], 32'd9);
    run_instr(64, enc_r(4'h8, 5'd17, 5'd5, 5'd12), 1);
    check("xor_r17", dbg_regs[17], 32'hFFFF_FFFA);
    run_instr(65, enc_r(4'hE, 5'd0, 5'd2, 5'd1), 2);
    check("nop_r0", dbg_regs[0], 32'd0);
    run_instr(66, 32'h0002_1CAB, 1);
    run_instr(76, 32'h0000_400D, 3);
    check("commit_count", 32'(commits), 32'd16);

    wait_req(1);
    imem.instr       = enc_r(4'h0, 5'd7, 5'd4, 5'd4);
    imem.instr_valid = 1'b1;
    @(negedge clk);
    imem.instr_valid = 1'b0;
    imem.instr       = '0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_req", 32'(imem.req_valid), 32'd0);
    check("abort_dbg_pc", dbg_pc, 32'd0);
    check("abort_r7", dbg_regs[7], 32'd7);
    @(negedge clk);
    rst = 1'b0;
    check("abort_no_commit", 32'(commits), 32'd16);
    check("abort_pc", imem.pc, 32'd1);
    run_instr(1, enc_m(4'h1, 5'd9, 5'd0, 18'd30), 2);
    check("dmem_reinit", dbg_regs[9], 32'd30);
    check("final_commits", 32'(commits), 32'd17);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
